// File: rtl/fifo_stream_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_pkg
// Description : Shared types for the FIFO stream reader: default data width,
//               word type and the reader FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef logic [DATA_W_DEFAULT-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_stream_reader_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_buf
// Description : Two-entry in-order buffer. Entry 0 is always the head that is
//               presented downstream; entry 1 holds the overflow word.
//               A push and a pop in the same cycle keep occupancy unchanged.
// Revision    : 1.0 - initial release
// Ports       :
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   push       in   write push_data this cycle
//   push_data  in   word to write
//   pop        in   remove the head this cycle (ignored when empty)
//   head       out  head entry (meaningful when occ != 0)
//   occ        out  number of stored words, 0..2
// ============================================================================
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] entry0;
  logic [DATA_W-1:0] entry1;
  logic [1:0]        count;
  logic              pop_ok;
  logic              push_ok;

  // A pop on an empty buffer or a push into a full, non-popping buffer
  // cannot happen with a well-behaved producer; they are masked so the
  // occupancy count can never leave 0..2.
  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Head leaves; the new word goes behind whatever remains.
          if (count == 2'd2) begin
            entry0 <= entry1;
            entry1 <= push_data;
          end else begin
            entry0 <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign head = entry0;
  assign occ  = count;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_stream_reader
// Description : Pops words from a synchronous FIFO (one-cycle read latency)
//               and presents them on a valid/ready stream through a 2-entry
//               skid buffer. Marks the last beat of every BURST_LEN-beat
//               burst and counts delivered words.
// Revision    : 1.0 - initial release
// Ports       :
//   clk              in   clock, all state on posedge
//   rst              in   asynchronous active-high reset
//   en               in   enable fetching from the FIFO
//   fifo_empty       in   FIFO empty flag
//   fifo_data_out    in   FIFO read data, valid the cycle after fifo_read
//   fifo_read        out  FIFO pop strobe
//   out_valid        out  stream valid
//   out_ready        in   stream ready
//   out_data         out  stream data (buffer head)
//   out_last         out  final beat of a burst
//   busy             out  FSM not idle
//   words_delivered  out  handshake count, wraps
// ============================================================================
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_read,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  words_delivered
);

  localparam int              BEAT_W    = 16;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  reader_state_t     state;
  reader_state_t     state_next;
  logic              inflight;
  logic [1:0]        occ;
  logic [BEAT_W-1:0] beat_cnt;
  logic              handshake;
  logic              room;
  logic              pending;

  stream_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_data_out),
    .pop       (handshake),
    .head      (out_data),
    .occ       (occ)
  );

  assign out_valid = (occ != 2'd0);
  assign handshake = out_valid && out_ready;
  assign out_last  = out_valid && (beat_cnt == LAST_BEAT);

  // Slots already claimed are the stored words plus the one in flight.
  // A handshake this cycle frees the head slot before the next word can
  // land, so it counts as room; without that credit a ready sink would see
  // a bubble every other word.
  assign room = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, handshake});

  // A word popped this very cycle is as good as in flight for deciding
  // whether the FSM still has something to deliver.
  assign pending = (occ != 2'd0) || inflight || fifo_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      inflight        <= 1'b0;
      beat_cnt        <= '0;
      words_delivered <= '0;
    end else begin
      state    <= state_next;
      inflight <= fifo_read;
      if (handshake) begin
        words_delivered <= words_delivered + CNT_W'(1);
        if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
        else                       beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    fifo_read  = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (en) state_next = RUN;
      end
      RUN: begin
        fifo_read = !fifo_empty && room;
        if (!en) state_next = pending ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (en)                               state_next = RUN;
        else if ((occ == 2'd0) && !inflight)  state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_stream_reader
// Description : Directed self-checking bench for fifo_stream_reader with a
//               behavioural one-cycle-latency FIFO and an output scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [15:0] fifo_data_out;
  logic        fifo_read;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic [15:0] words_delivered;

  int checks   = 0;
  int failures = 0;

  // FIFO model storage
  logic [15:0] fmem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;

  // Scoreboard of accepted beats
  logic [15:0] outs  [0:255];
  logic        lasts [0:255];
  int          n_out = 0;

  logic        rd_empty_viol = 1'b0;
  logic [1:0]  max_occ = 2'd0;

  fifo_stream_reader #(
    .DATA_W    (16),
    .BURST_LEN (4),
    .CNT_W     (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .fifo_empty      (fifo_empty),
    .fifo_data_out   (fifo_data_out),
    .fifo_read       (fifo_read),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy),
    .words_delivered (words_delivered)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);

  initial fifo_data_out = 16'h0;

  always @(posedge clk) begin
    if (fifo_read) begin
      fifo_data_out <= fmem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
    if (fifo_read && fifo_empty) rd_empty_viol <= 1'b1;
    if (dut.occ > max_occ) max_occ <= dut.occ;
    if (out_valid && out_ready) begin
      outs[n_out[7:0]]  <= out_data;
      lasts[n_out[7:0]] <= out_last;
      n_out             <= n_out + 1;
    end
  end

  task automatic load(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr] = base + 16'(i);
      wr_ptr       = wr_ptr + 8'd1;
    end
  endtask

  task automatic apply_reset();
    en        = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (fifo_read !== 1'b0) begin failures++; $display("FAIL reset_fifo_read got=%b exp=0", fifo_read); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (words_delivered !== 16'h0) begin failures++; $display("FAIL reset_words got=%0d exp=0", words_delivered); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Three preloaded words, ready sink: three back-to-back pops, data
  // appears two cycles after the first pop and streams one per cycle.
  task automatic test_basic_stream();
    load(16'd1, 3);
    out_ready = 1'b1;
    en        = 1'b1;
    @(negedge clk);
    checks++; if (fifo_read !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_c1 got read=%b valid=%b exp read=1 valid=0", fifo_read, out_valid); end
    @(negedge clk);
    checks++; if (fifo_read !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_c2 got read=%b valid=%b exp read=1 valid=0", fifo_read, out_valid); end
    @(negedge clk);
    checks++; if (fifo_read !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'd1) begin failures++; $display("FAIL basic_c3 got read=%b valid=%b data=%0d exp 1 1 1", fifo_read, out_valid, out_data); end
    @(negedge clk);
    checks++; if (fifo_read !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd2) begin failures++; $display("FAIL basic_c4 got read=%b valid=%b data=%0d exp 0 1 2", fifo_read, out_valid, out_data); end
    @(negedge clk);
    checks++; if (fifo_read !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd3) begin failures++; $display("FAIL basic_c5 got read=%b valid=%b data=%0d exp 0 1 3", fifo_read, out_valid, out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || words_delivered !== 16'd3) begin failures++; $display("FAIL basic_done got valid=%b words=%0d exp valid=0 words=3", out_valid, words_delivered); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got busy=%b exp 0", busy); end
  endtask

  // Stalled sink: only two pops, head held; release delivers all in order.
  task automatic test_stall();
    logic [7:0] rd0;
    int         s;
    int         i;
    rd0 = rd_ptr;
    s   = n_out;
    out_ready = 1'b0;
    load(16'd10, 10);
    en = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (out_data !== 16'd10 || out_valid !== 1'b1) begin failures++; $display("FAIL stall_head_mid got valid=%b data=%0d exp 1 10", out_valid, out_data); end
    repeat (2) @(negedge clk);
    checks++; if (8'(rd_ptr - rd0) !== 8'd2 || fifo_read !== 1'b0) begin failures++; $display("FAIL stall_pops got pops=%0d read=%b exp pops=2 read=0", 8'(rd_ptr - rd0), fifo_read); end
    checks++; if (out_data !== 16'd10) begin failures++; $display("FAIL stall_head_end got %0d exp 10", out_data); end
    out_ready = 1'b1;
    for (i = 0; i < 60 && (n_out - s) < 10; i++) @(negedge clk);
    checks++; if ((n_out - s) != 10) begin failures++; $display("FAIL stall_timeout got %0d beats exp 10", n_out - s); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (outs[8'(s + k)] !== 16'(10 + k)) begin failures++; $display("FAIL stall_order beat %0d got %0d exp %0d", k, outs[8'(s + k)], 10 + k); end
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_idle got busy=%b exp 0", busy); end
  endtask

  // BURST_LEN=4: out_last on beats 4 and 8 of 9.
  task automatic test_burst_last();
    int s;
    int i;
    apply_reset();
    s = n_out;
    out_ready = 1'b1;
    load(16'h30, 9);
    en = 1'b1;
    for (i = 0; i < 40 && (n_out - s) < 9; i++) @(negedge clk);
    checks++; if ((n_out - s) != 9) begin failures++; $display("FAIL burst_timeout got %0d beats exp 9", n_out - s); end
    for (int k = 0; k < 9; k++) begin
      checks++; if (lasts[8'(s + k)] !== ((k == 3) || (k == 7))) begin failures++; $display("FAIL burst_last beat %0d got %b exp %b", k + 1, lasts[8'(s + k)], ((k == 3) || (k == 7))); end
    end
    checks++; if (words_delivered !== 16'd9) begin failures++; $display("FAIL burst_words got %0d exp 9", words_delivered); end
    en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // en drops in the pop cycle: DRAIN, word delivered, then IDLE, no pops.
  task automatic test_en_drop();
    logic stray;
    load(16'hA0, 5);
    out_ready = 1'b1;
    en        = 1'b1;
    @(negedge clk);
    checks++; if (fifo_read !== 1'b1) begin failures++; $display("FAIL drop_pop got read=%b exp 1", fifo_read); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (dut.state !== DRAIN || fifo_read !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL drop_drain got state=%0d read=%b busy=%b exp 2 0 1", dut.state, fifo_read, busy); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hA0) begin failures++; $display("FAIL drop_data got valid=%b data=%h exp 1 00a0", out_valid, out_data); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL drop_tail got busy=%b valid=%b exp 1 0", busy, out_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || words_delivered !== 16'd10) begin failures++; $display("FAIL drop_idle got busy=%b words=%0d exp 0 10", busy, words_delivered); end
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (fifo_read) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL drop_no_read got stray=%b exp 0", stray); end
  endtask

  // Async reset between edges mid-stream, then refill.
  task automatic test_async_reset();
    logic [7:0] rel;
    int         s;
    int         i;
    load(16'hC0, 8);
    out_ready = 1'b1;
    en        = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got valid=%b exp 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_read !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL arst_now got valid=%b read=%b busy=%b exp 0 0 0", out_valid, fifo_read, busy); end
    checks++; if (words_delivered !== 16'd0 || out_last !== 1'b0) begin failures++; $display("FAIL arst_cnt got words=%0d last=%b exp 0 0", words_delivered, out_last); end
    @(negedge clk);
    rst = 1'b0;
    rel = rd_ptr;
    s   = n_out;
    for (i = 0; i < 30 && (n_out - s) < 4; i++) @(negedge clk);
    checks++; if ((n_out - s) < 4) begin failures++; $display("FAIL arst_timeout got %0d beats exp 4", n_out - s); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (lasts[8'(s + k)] !== (k == 3) || outs[8'(s + k)] !== fmem[8'(rel + 8'(k))]) begin failures++; $display("FAIL arst_beat %0d got last=%b data=%h exp last=%b data=%h", k + 1, lasts[8'(s + k)], outs[8'(s + k)], (k == 3), fmem[8'(rel + 8'(k))]); end
    end
    checks++; if (words_delivered !== 16'(n_out - s)) begin failures++; $display("FAIL arst_words got %0d exp %0d", words_delivered, n_out - s); end
    en = 1'b0;
    for (i = 0; i < 10 && busy; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_drain got busy=%b exp 0", busy); end
  endtask

  // Random sink backpressure over everything left in the FIFO plus 20 words.
  task automatic test_random_ready();
    logic [7:0] rd0;
    int         s;
    int         total;
    int         i;
    rd0 = rd_ptr;
    s   = n_out;
    load(16'h100, 20);
    total = int'(8'(wr_ptr - rd0));
    en    = 1'b1;
    for (i = 0; i < 600 && (n_out - s) < total; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++; if ((n_out - s) != total) begin failures++; $display("FAIL rand_timeout got %0d beats exp %0d", n_out - s, total); end
    for (int k = 0; k < total; k++) begin
      checks++; if (outs[8'(s + k)] !== fmem[8'(rd0 + 8'(k))]) begin failures++; $display("FAIL rand_order beat %0d got %h exp %h", k, outs[8'(s + k)], fmem[8'(rd0 + 8'(k))]); end
    end
    checks++; if (rd_empty_viol !== 1'b0) begin failures++; $display("FAIL rand_read_empty got %b exp 0", rd_empty_viol); end
    checks++; if (max_occ > 2'd2) begin failures++; $display("FAIL rand_occ got %0d exp <=2", max_occ); end
    en = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rand_idle got busy=%b exp 0", busy); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic_stream();
    test_stall();
    test_burst_last();
    test_en_drop();
    test_async_reset();
    test_random_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
